// File: rtl/axi_ar_4k_splitter.sv
// axi_ar_4k_splitter
//   Per-master AXI read-address stage in front of the crossbar arbitration.
//   - INCR bursts that cross a 4 KB boundary are issued as two downstream bursts.
//   - The master index is prefixed onto ARID.
//   - Same-ID requests to different 4 KB regions are held back until the
//     earlier burst has returned RLAST, using a small outstanding table.
//   - Read data of a split burst is merged back into one burst with a single
//     RLAST toward the master.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axi_index       static master number, prefixed onto ARID
//   s_axi_ar_*        read-address channel from the master
//   m_axi_ar_*        read-address channel toward the crossbar
//   m_axi_r_*         read-data channel from the crossbar
//   s_axi_r_*         read-data channel toward the master
module axi_ar_4k_splitter #(
  parameter int ADDR_W    = 14,
  parameter int ID_W      = 4,
  parameter int IDX_W     = 2,
  parameter int DATA_W    = 32,
  parameter int OST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      s_axi_index,
  input  logic [ADDR_W-1:0]     s_axi_ar_addr,
  input  logic [7:0]            s_axi_ar_arlen,
  input  logic [2:0]            s_axi_ar_arsize,
  input  logic [1:0]            s_axi_ar_arburst,
  input  logic [ID_W-1:0]       s_axi_ar_arid,
  input  logic                  s_axi_ar_valid,
  output logic                  s_axi_ar_ready,
  output logic [ADDR_W-1:0]     m_axi_ar_addr,
  output logic [7:0]            m_axi_ar_arlen,
  output logic [2:0]            m_axi_ar_arsize,
  output logic [1:0]            m_axi_ar_arburst,
  output logic [ID_W+IDX_W-1:0] m_axi_ar_arid,
  output logic                  m_axi_ar_valid,
  input  logic                  m_axi_ar_ready,
  input  logic [DATA_W-1:0]     m_axi_r_rdata,
  input  logic [1:0]            m_axi_r_rresp,
  input  logic [ID_W+IDX_W-1:0] m_axi_r_rid,
  input  logic                  m_axi_r_rlast,
  input  logic                  m_axi_r_valid,
  output logic                  m_axi_r_ready,
  output logic [DATA_W-1:0]     s_axi_r_rdata,
  output logic [1:0]            s_axi_r_rresp,
  output logic [ID_W-1:0]       s_axi_r_rid,
  output logic                  s_axi_r_rlast,
  output logic                  s_axi_r_valid,
  input  logic                  s_axi_r_ready
);

  localparam int RID_W = ID_W + IDX_W;
  localparam int REG_W = ADDR_W - 12;
  localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OST_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE1 = 2'd1, ISSUE2 = 2'd2} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic [1:0]        req_burst;
  logic [ID_W-1:0]   req_id;

  logic [OST_DEPTH-1:0] tbl_valid;
  logic [OST_DEPTH-1:0] tbl_split;
  logic [RID_W-1:0]     tbl_id     [OST_DEPTH];
  logic [REG_W-1:0]     tbl_region [OST_DEPTH];

  logic [11:0]      a0;
  logic [12:0]      beats;
  logic [8:0]       len_p1;
  logic             is_split;
  logic [REG_W-1:0] region;
  logic [REG_W-1:0] region2;
  logic [REG_W-1:0] piece_region;
  logic [RID_W-1:0] full_id;

  // Beats that fit before the next 4 KB boundary, from the size-aligned start.
  assign a0       = req_addr[11:0] & ~((12'h1 << req_size) - 12'h1);
  assign beats    = (13'h1000 - {1'b0, a0}) >> req_size;
  assign len_p1   = {1'b0, req_len} + 9'd1;
  assign is_split = (req_burst == 2'b01) && ({4'b0, len_p1} > beats);

  assign region       = req_addr[ADDR_W-1:12];
  assign region2      = region + REG_W'(1);
  assign piece_region = (state == ISSUE2) ? region2 : region;
  assign full_id      = {s_axi_index, req_id};

  logic             conflict;
  logic [CNT_W-1:0] free_cnt;
  logic [PTR_W-1:0] alloc_idx;
  logic             alloc_found;
  logic [PTR_W-1:0] match_idx;
  logic             match_hit;

  always_comb begin
    conflict    = 1'b0;
    free_cnt    = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    match_idx   = '0;
    match_hit   = 1'b0;
    for (int i = 0; i < OST_DEPTH; i++) begin
      if (tbl_valid[i] && (tbl_id[i] == full_id) && (tbl_region[i] != piece_region))
        conflict = 1'b1;
      if (!tbl_valid[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!alloc_found) begin
          alloc_idx   = PTR_W'(i);
          alloc_found = 1'b1;
        end
      end
      if (tbl_valid[i] && (tbl_id[i] == m_axi_r_rid) && !match_hit) begin
        match_idx = PTR_W'(i);
        match_hit = 1'b1;
      end
    end
  end

  logic m_hs;
  logic r_free;

  assign s_axi_ar_ready   = (state == IDLE) && (free_cnt >= CNT_W'(2));
  assign m_axi_ar_valid   = (state != IDLE) && !conflict;
  assign m_axi_ar_addr    = (state == ISSUE2) ? {region2, 12'h000} : req_addr;
  assign m_axi_ar_arlen   = (state == ISSUE2) ? (req_len - beats[7:0]) :
                            (is_split ? (beats[7:0] - 8'd1) : req_len);
  assign m_axi_ar_arsize  = req_size;
  assign m_axi_ar_arburst = req_burst;
  assign m_axi_ar_arid    = full_id;

  assign m_hs   = m_axi_ar_valid && m_axi_ar_ready;
  assign r_free = m_axi_r_valid && s_axi_r_ready && m_axi_r_rlast && match_hit;

  assign s_axi_r_valid = m_axi_r_valid;
  assign m_axi_r_ready = s_axi_r_ready;
  assign s_axi_r_rdata = m_axi_r_rdata;
  assign s_axi_r_rresp = m_axi_r_rresp;
  assign s_axi_r_rid   = m_axi_r_rid[ID_W-1:0];
  // The first piece of a split burst must not end the master's burst.
  assign s_axi_r_rlast = m_axi_r_rlast && !(match_hit && tbl_split[match_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_len   <= '0;
      req_size  <= '0;
      req_burst <= '0;
      req_id    <= '0;
    end else begin
      case (state)
        IDLE: if (s_axi_ar_valid && s_axi_ar_ready) begin
          req_addr  <= s_axi_ar_addr;
          req_len   <= s_axi_ar_arlen;
          req_size  <= s_axi_ar_arsize;
          req_burst <= s_axi_ar_arburst;
          req_id    <= s_axi_ar_arid;
          state     <= ISSUE1;
        end
        ISSUE1: if (m_hs) state <= is_split ? ISSUE2 : IDLE;
        ISSUE2: if (m_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free and allocate never target the same slot: allocation picks from
  // entries that were already invalid at the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      tbl_split <= '0;
      for (int i = 0; i < OST_DEPTH; i++) begin
        tbl_id[i]     <= '0;
        tbl_region[i] <= '0;
      end
    end else begin
      if (r_free) tbl_valid[match_idx] <= 1'b0;
      if (m_hs) begin
        tbl_valid[alloc_idx]  <= 1'b1;
        tbl_id[alloc_idx]     <= full_id;
        tbl_region[alloc_idx] <= piece_region;
        tbl_split[alloc_idx]  <= (state == ISSUE1) && is_split;
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_4k_splitter.sv
module tb_axi_ar_4k_splitter;
  localparam int ADDR_W = 14, ID_W = 4, IDX_W = 2, DATA_W = 32, OST_DEPTH = 4;
  localparam int RID_W = ID_W + IDX_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [IDX_W-1:0]  index;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [ID_W-1:0]   ar_id;
  logic              ar_valid;
  logic              s_ar_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_len;
  logic [2:0]        m_size;
  logic [1:0]        m_burst;
  logic [RID_W-1:0]  m_id;
  logic              m_ar_valid;
  logic              m_ar_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [RID_W-1:0]  r_id;
  logic              r_last;
  logic              r_valid;
  logic              m_r_ready;
  logic [DATA_W-1:0] s_r_data;
  logic [1:0]        s_r_resp;
  logic [ID_W-1:0]   s_r_id;
  logic              s_r_last;
  logic              s_r_valid;
  logic              s_r_ready;

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  int lasts_seen = 0;

  axi_ar_4k_splitter #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .IDX_W(IDX_W), .DATA_W(DATA_W), .OST_DEPTH(OST_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi_index(index),
    .s_axi_ar_addr(ar_addr), .s_axi_ar_arlen(ar_len), .s_axi_ar_arsize(ar_size),
    .s_axi_ar_arburst(ar_burst), .s_axi_ar_arid(ar_id), .s_axi_ar_valid(ar_valid),
    .s_axi_ar_ready(s_ar_ready),
    .m_axi_ar_addr(m_addr), .m_axi_ar_arlen(m_len), .m_axi_ar_arsize(m_size),
    .m_axi_ar_arburst(m_burst), .m_axi_ar_arid(m_id), .m_axi_ar_valid(m_ar_valid),
    .m_axi_ar_ready(m_ar_ready),
    .m_axi_r_rdata(r_data), .m_axi_r_rresp(r_resp), .m_axi_r_rid(r_id),
    .m_axi_r_rlast(r_last), .m_axi_r_valid(r_valid), .m_axi_r_ready(m_r_ready),
    .s_axi_r_rdata(s_r_data), .s_axi_r_rresp(s_r_resp), .s_axi_r_rid(s_r_id),
    .s_axi_r_rlast(s_r_last), .s_axi_r_valid(s_r_valid), .s_axi_r_ready(s_r_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: how a request is cut at the 4 KB boundary, in byte arithmetic.
  function automatic void model(input int addr, input int len, input int size, input int burst,
                                output int split, output int len1, output int addr2, output int len2);
    int off;
    int bytes;
    int fit;
    bytes = 1 << size;
    off   = addr % 4096;
    off   = off - (off % bytes);
    fit   = (4096 - off) / bytes;
    split = (burst == 1 && (len + 1) > fit) ? 1 : 0;
    len1  = split ? fit - 1 : len;
    addr2 = (((addr / 4096) + 1) % (1 << (ADDR_W - 12))) * 4096;
    len2  = len - fit;
  endfunction

  task automatic send_ar(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [ID_W-1:0] id, input string name);
    int n = 0;
    @(negedge clk);
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
    #1;
    while (!s_ar_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!s_ar_ready) begin
      failures++;
      $display("FAIL %s: s_axi_ar_ready timeout, got 0 required 1", name);
      ar_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic expect_ar(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [RID_W-1:0] id, input string name);
    int n = 0;
    int stall = $urandom_range(0, 2);
    @(negedge clk); #1;
    while (!m_ar_valid && n < 300) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!m_ar_valid) begin
      failures++;
      $display("FAIL %s: m_axi_ar_valid timeout, got 0 required 1", name);
      return;
    end
    repeat (stall) begin
      @(negedge clk); #1;
      checks++;
      if (m_ar_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_stall: m_axi_ar_valid got %b required 1", name, m_ar_valid);
      end
    end
    m_ar_ready = 1'b1;
    #1;
    checks++;
    if ({m_addr, m_len, m_size, m_burst, m_id} !== {addr, len, size, burst, id}) begin
      failures++;
      $display("FAIL %s: got addr=%h len=%0d size=%0d burst=%0d id=%h required addr=%h len=%0d size=%0d burst=%0d id=%h",
               name, m_addr, m_len, m_size, m_burst, m_id, addr, len, size, burst, id);
    end
    @(posedge clk); #1;
    m_ar_ready = 1'b0;
  endtask

  task automatic r_beats(input logic [RID_W-1:0] id, input int n, input bit exp_last, input string name);
    logic exp_l;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r_valid = 1'b1; r_data = $urandom; r_resp = 2'($urandom_range(0, 3));
      r_id = id; r_last = (i == n - 1);
      if ($urandom_range(0, 3) == 0) begin
        s_r_ready = 1'b0;
        #1;
        checks++;
        if (m_r_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_rready: m_axi_r_ready got %b required 0", name, m_r_ready);
        end
        @(negedge clk);
      end
      s_r_ready = 1'b1;
      #1;
      exp_l = (i == n - 1) && exp_last;
      checks++;
      if ({s_r_valid, m_r_ready, s_r_data, s_r_resp, s_r_id, s_r_last} !==
          {1'b1, 1'b1, r_data, r_resp, id[ID_W-1:0], exp_l}) begin
        failures++;
        $display("FAIL %s_beat%0d: got v=%b rdy=%b d=%h resp=%0d id=%h last=%b required v=1 rdy=1 d=%h resp=%0d id=%h last=%b",
                 name, i, s_r_valid, m_r_ready, s_r_data, s_r_resp, s_r_id, s_r_last,
                 r_data, r_resp, id[ID_W-1:0], exp_l);
      end
      beats_seen++;
      if (s_r_last) lasts_seen++;
      @(posedge clk); #1;
      r_valid = 1'b0; r_last = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({s_ar_ready, m_ar_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset: got ar_ready=%b ar_valid=%b required ar_ready=1 ar_valid=0", s_ar_ready, m_ar_valid);
    end
  endtask

  task automatic test_split();
    send_ar(14'h0FF0, 8'd7, 3'd2, 2'b01, 4'd3, "split_send");
    checks++;
    if (m_ar_valid !== 1'b1) begin
      failures++;
      $display("FAIL split_latency: m_axi_ar_valid got %b required 1", m_ar_valid);
    end
    expect_ar(14'h0FF0, 8'd3, 3'd2, 2'b01, 6'h23, "split_p1");
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if ({m_ar_valid, s_ar_ready} !== 2'b00) begin
        failures++;
        $display("FAIL split_p2_held: got valid=%b ar_ready=%b required 0 0", m_ar_valid, s_ar_ready);
      end
    end
    beats_seen = 0; lasts_seen = 0;
    r_beats(6'h23, 4, 1'b0, "split_r1");
    expect_ar(14'h1000, 8'd3, 3'd2, 2'b01, 6'h23, "split_p2");
    r_beats(6'h23, 4, 1'b1, "split_r2");
    checks++;
    if (beats_seen != 8 || lasts_seen != 1) begin
      failures++;
      $display("FAIL split_merge: got beats=%0d rlasts=%0d required 8 1", beats_seen, lasts_seen);
    end
  endtask

  task automatic test_exact_fit();
    send_ar(14'h0F00, 8'd63, 3'd2, 2'b01, 4'd1, "fit_send");
    expect_ar(14'h0F00, 8'd63, 3'd2, 2'b01, 6'h21, "fit_ar");
    @(negedge clk); #1;
    checks++;
    if ({m_ar_valid, s_ar_ready} !== 2'b01) begin
      failures++;
      $display("FAIL fit_idle: got valid=%b ar_ready=%b required 0 1", m_ar_valid, s_ar_ready);
    end
    r_beats(6'h21, 64, 1'b1, "fit_r");
  endtask

  task automatic test_wrap();
    send_ar(14'h0FF8, 8'd3, 3'd2, 2'b10, 4'd5, "wrap_send");
    expect_ar(14'h0FF8, 8'd3, 3'd2, 2'b10, 6'h25, "wrap_ar");
    r_beats(6'h25, 4, 1'b1, "wrap_r");
  endtask

  task automatic test_ordering();
    send_ar(14'h0100, 8'd0, 3'd2, 2'b01, 4'd7, "ord_send0");
    expect_ar(14'h0100, 8'd0, 3'd2, 2'b01, 6'h27, "ord_ar0");
    send_ar(14'h1100, 8'd0, 3'd2, 2'b01, 4'd7, "ord_send1");
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (m_ar_valid !== 1'b0) begin
        failures++;
        $display("FAIL ord_held: m_axi_ar_valid got %b required 0", m_ar_valid);
      end
    end
    r_beats(6'h27, 1, 1'b1, "ord_r0");
    checks++;
    if (m_ar_valid !== 1'b1) begin
      failures++;
      $display("FAIL ord_release: m_axi_ar_valid got %b required 1", m_ar_valid);
    end
    expect_ar(14'h1100, 8'd0, 3'd2, 2'b01, 6'h27, "ord_ar1");
    r_beats(6'h27, 1, 1'b1, "ord_r1");
  endtask

  task automatic test_full();
    for (int k = 1; k <= 3; k++) begin
      send_ar(14'h0100, 8'd0, 3'd2, 2'b01, 4'(k), "full_send");
      expect_ar(14'h0100, 8'd0, 3'd2, 2'b01, {2'd2, 4'(k)}, "full_ar");
    end
    @(negedge clk); #1;
    checks++;
    if (s_ar_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_block: s_axi_ar_ready got %b required 0", s_ar_ready);
    end
    r_beats(6'h21, 1, 1'b1, "full_r1");
    @(negedge clk); #1;
    checks++;
    if (s_ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_restore: s_axi_ar_ready got %b required 1", s_ar_ready);
    end
    r_beats(6'h22, 1, 1'b1, "full_r2");
    r_beats(6'h23, 1, 1'b1, "full_r3");
  endtask

  task automatic test_reset_issue2();
    send_ar(14'h0FF0, 8'd7, 3'd2, 2'b01, 4'd6, "rst_send");
    expect_ar(14'h0FF0, 8'd3, 3'd2, 2'b01, 6'h26, "rst_p1");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ar_valid, s_ar_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_async: got valid=%b ar_ready=%b required 0 1", m_ar_valid, s_ar_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (m_ar_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_dropped: m_axi_ar_valid got %b required 0", m_ar_valid);
      end
    end
    send_ar(14'h1100, 8'd0, 3'd2, 2'b01, 4'd6, "rst_send2");
    checks++;
    if (m_ar_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_table_clear: m_axi_ar_valid got %b required 1", m_ar_valid);
    end
    expect_ar(14'h1100, 8'd0, 3'd2, 2'b01, 6'h26, "rst_ar2");
    r_beats(6'h26, 1, 1'b1, "rst_r2");
  endtask

  task automatic test_random();
    int addr, len, size, burst, id;
    int split, len1, addr2, len2;
    for (int it = 0; it < 30; it++) begin
      size  = $urandom_range(0, 2);
      burst = $urandom_range(0, 2);
      id    = $urandom_range(0, 15);
      len   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0)
        addr = ($urandom_range(0, 3) * 4096) + 4096 - $urandom_range(1, 64);
      else
        addr = $urandom_range(0, 16383);
      model(addr, len, size, burst, split, len1, addr2, len2);
      send_ar(14'(addr), 8'(len), 3'(size), 2'(burst), 4'(id), "rnd_send");
      expect_ar(14'(addr), 8'(len1), 3'(size), 2'(burst), {2'd2, 4'(id)}, "rnd_p1");
      r_beats({2'd2, 4'(id)}, len1 + 1, split == 0, "rnd_r1");
      if (split != 0) begin
        expect_ar(14'(addr2), 8'(len2), 3'(size), 2'(burst), {2'd2, 4'(id)}, "rnd_p2");
        r_beats({2'd2, 4'(id)}, len2 + 1, 1'b1, "rnd_r2");
      end
    end
  endtask

  initial begin
    index = 2'd2;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_id = '0; ar_valid = 1'b0;
    m_ar_ready = 1'b0;
    r_data = '0; r_resp = '0; r_id = '0; r_last = 1'b0; r_valid = 1'b0; s_r_ready = 1'b1;
    test_reset();
    test_split();
    test_exact_fit();
    test_wrap();
    test_ordering();
    test_full();
    test_reset_issue2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
